// File: rtl/mxv_tx_capture_seq_pkg.sv
// Shared types and default sizing for the MxV-to-UART capture sequencer.
package mxv_tx_pkg;

    typedef enum logic [1:0] {
        CAP  = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } tx_cap_state_e;

    localparam int DEF_MAX_N = 16;
    localparam int DEF_N_W   = 8;

endpackage

// File: rtl/mxv_tx_capture_seq_if.sv
// Handshake bundle between the result datapath / transmit counter and the capture sequencer.
interface mxv_tx_capture_seq_if
    import mxv_tx_pkg::*;
#(
    parameter int MAX_N = DEF_MAX_N,
    parameter int N_W   = DEF_N_W
);
    localparam int IDX_W = $clog2(MAX_N + 1);

    logic             pulse;
    logic [N_W-1:0]   n;
    logic             max_flag;
    logic [MAX_N-1:0] capture;
    logic             capture_valid;
    logic [IDX_W-1:0] capture_idx;
    logic             count;
    logic             frame_done;
    logic             n_err;

    modport master (
        output pulse, n, max_flag,
        input  capture, capture_valid, capture_idx, count, frame_done, n_err
    );

    modport slave (
        input  pulse, n, max_flag,
        output capture, capture_valid, capture_idx, count, frame_done, n_err
    );

endinterface

// File: rtl/mxv_tx_capture_seq_pulse_sync.sv
// Optional flop chain on the element step strobe; STAGES=0 passes it straight through.
module pulse_sync #(
    parameter int STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign q = d;
        end else begin : g_flops
            logic [STAGES-1:0] sr;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sr <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mxv_tx_capture_seq.sv
// Walks result elements 0..n-1 with a one-hot capture strobe, then holds count until max_flag.
//
// state | meaning
// CAP   | waiting for the step pulse of element idx, or for idx to reach n
// HOLD  | capture[idx] high while the step pulse stays high
// WAIT  | frame complete, count high until the transmit counter reports max_flag
module mxv_tx_capture_seq
    import mxv_tx_pkg::*;
#(
    parameter int MAX_N       = DEF_MAX_N,
    parameter int N_W         = DEF_N_W,
    parameter int SYNC_STAGES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    mxv_tx_capture_seq_if.slave   bus
);

    localparam int IDX_W = $clog2(MAX_N + 1);
    localparam int CMP_W = (N_W > IDX_W) ? N_W : IDX_W;

    localparam logic [1:0] ST_CAP  = CAP;
    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_WAIT = WAIT;

    localparam logic [N_W-1:0] N_LIMIT = N_W'(MAX_N);

    logic             p;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [CMP_W-1:0] idx_x;
    logic [CMP_W-1:0] n_x;
    logic             n_err;
    logic [MAX_N-1:0] capture;

    pulse_sync #(
        .STAGES (SYNC_STAGES)
    ) u_pulse_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pulse),
        .q     (p)
    );

    // n is live: compared every cycle, never latched
    assign n_err = bus.n > N_LIMIT;
    assign idx_x = CMP_W'(idx);
    assign n_x   = CMP_W'(bus.n);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (n_err) begin
            state_nxt = ST_CAP;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_CAP: begin
                    if (idx_x >= n_x) begin
                        state_nxt = ST_WAIT;
                    end else if (p) begin
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!p) begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ST_CAP;
                    end
                end
                ST_WAIT: begin
                    if (bus.max_flag) begin
                        idx_nxt   = '0;
                        state_nxt = ST_CAP;
                    end
                end
                default: begin
                    state_nxt = ST_CAP;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_CAP;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // HOLD only occurs with idx < n <= MAX_N, so the shift never falls off the bus
    assign capture = (state == ST_HOLD && !n_err) ? (MAX_N'(1) << idx) : '0;

    assign bus.capture       = capture;
    assign bus.capture_valid = |capture;
    assign bus.capture_idx   = idx;
    assign bus.count         = (state == ST_WAIT) && !n_err;
    assign bus.frame_done    = (state == ST_WAIT) && bus.max_flag && !n_err;
    assign bus.n_err         = n_err;

endmodule

// File: tb/tb_mxv_tx_capture_seq.sv
// Directed bench for the capture sequencer: one unsynchronised instance and one with a 2-flop pulse sync.
module tb_mxv_tx_capture_seq;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    mxv_tx_capture_seq_if #(.MAX_N(16), .N_W(8)) bus0 ();
    mxv_tx_capture_seq_if #(.MAX_N(16), .N_W(8)) bus1 ();

    mxv_tx_capture_seq #(.MAX_N(16), .N_W(8), .SYNC_STAGES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mxv_tx_capture_seq #(.MAX_N(16), .N_W(8), .SYNC_STAGES(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    logic [15:0] exp_cap [12] = '{16'h1, 16'h1, 16'h0, 16'h0, 16'h2, 16'h2,
                                  16'h0, 16'h0, 16'h4, 16'h4, 16'h0, 16'h0};
    logic [4:0]  exp_idx [12] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1,
                                  5'd2, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3};
    logic        pat     [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        bus0.pulse = 1'b0; bus0.n = 8'd3; bus0.max_flag = 1'b0;
        bus1.pulse = 1'b0; bus1.n = 8'd3; bus1.max_flag = 1'b0;

        #12;
        check_eq("rst_capture", bus0.capture, 16'h0);
        check_eq("rst_count", bus0.count, 1'b0);
        check_eq("rst_idx", bus0.capture_idx, 5'd0);
        check_eq("rst_frame_done", bus0.frame_done, 1'b0);
        reset = 1'b1;
        tick();

        // n=3 frame: three (2 high, 2 low) pulses
        for (int c = 0; c < 12; c++) begin
            bus0.pulse = pat[c];
            tick();
            check_eq($sformatf("n3_cap_c%0d", c), bus0.capture, exp_cap[c]);
            check_eq($sformatf("n3_idx_c%0d", c), bus0.capture_idx, exp_idx[c]);
            check_eq($sformatf("n3_count_c%0d", c), bus0.count, (c == 11) ? 1'b1 : 1'b0);
        end
        check_eq("n3_valid_idle", bus0.capture_valid, 1'b0);
        tick();
        check_eq("n3_wait_count", bus0.count, 1'b1);
        bus0.max_flag = 1'b1;
        #1;
        check_eq("n3_frame_done", bus0.frame_done, 1'b1);
        tick();
        bus0.max_flag = 1'b0;
        #1;
        check_eq("n3_frame_done_width", bus0.frame_done, 1'b0);
        check_eq("n3_exit_count", bus0.count, 1'b0);
        check_eq("n3_exit_idx", bus0.capture_idx, 5'd0);

        // n=0: immediate WAIT, pulses ignored
        reset = 1'b0;
        bus0.n = 8'd0;
        #1;
        reset = 1'b1;
        tick();
        check_eq("n0_count", bus0.count, 1'b1);
        bus0.pulse = 1'b1;
        tick();
        check_eq("n0_no_capture", bus0.capture, 16'h0);
        check_eq("n0_count_hold", bus0.count, 1'b1);
        bus0.pulse = 1'b0;
        tick();
        bus0.max_flag = 1'b1;
        #1;
        check_eq("n0_frame_done", bus0.frame_done, 1'b1);
        tick();
        bus0.max_flag = 1'b0;
        #1;
        check_eq("n0_cap_count", bus0.count, 1'b0);
        check_eq("n0_cap_frame_done", bus0.frame_done, 1'b0);
        tick();
        check_eq("n0_rewait", bus0.count, 1'b1);

        // n=MAX_N full frame
        reset = 1'b0;
        bus0.n = 8'd16;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] one_hot;
            one_hot = 16'h1 << i;
            bus0.pulse = 1'b1;
            tick();
            check_eq($sformatf("n16_cap_%0d", i), bus0.capture, one_hot);
            check_eq($sformatf("n16_idx_%0d", i), bus0.capture_idx, 5'(i));
            bus0.pulse = 1'b0;
            tick();
            check_eq($sformatf("n16_gap_%0d", i), bus0.capture, 16'h0);
        end
        check_eq("n16_peak_idx", bus0.capture_idx, 5'd16);
        check_eq("n16_peak_count", bus0.count, 1'b0);
        tick();
        check_eq("n16_wait_count", bus0.count, 1'b1);
        check_eq("n16_wait_idx", bus0.capture_idx, 5'd16);
        bus0.max_flag = 1'b1;
        tick();
        bus0.max_flag = 1'b0;
        check_eq("n16_exit_idx", bus0.capture_idx, 5'd0);

        // out of range mid-frame at idx=5
        bus0.n = 8'd8;
        for (int i = 0; i < 5; i++) begin
            bus0.pulse = 1'b1;
            tick();
            bus0.pulse = 1'b0;
            tick();
        end
        check_eq("oor_pre_idx", bus0.capture_idx, 5'd5);
        bus0.pulse = 1'b1;
        tick();
        check_eq("oor_pre_cap", bus0.capture, 16'h0020);
        bus0.n = 8'd17;
        #1;
        check_eq("oor_n_err", bus0.n_err, 1'b1);
        check_eq("oor_cap_gated", bus0.capture, 16'h0);
        check_eq("oor_count", bus0.count, 1'b0);
        tick();
        check_eq("oor_idx_clr", bus0.capture_idx, 5'd0);
        check_eq("oor_cap_clr", bus0.capture, 16'h0);
        bus0.pulse = 1'b0;
        bus0.n = 8'd4;
        tick();
        check_eq("oor_n_err_clr", bus0.n_err, 1'b0);
        check_eq("oor_restart_idx", bus0.capture_idx, 5'd0);
        bus0.pulse = 1'b1;
        tick();
        check_eq("oor_restart_cap", bus0.capture, 16'h0001);

        // async reset during HOLD at idx=2
        bus0.pulse = 1'b0; tick();
        bus0.pulse = 1'b1; tick();
        bus0.pulse = 1'b0; tick();
        bus0.pulse = 1'b1; tick();
        check_eq("rst_mid_pre_cap", bus0.capture, 16'h0004);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_cap", bus0.capture, 16'h0);
        check_eq("rst_mid_count", bus0.count, 1'b0);
        check_eq("rst_mid_idx", bus0.capture_idx, 5'd0);
        bus0.pulse = 1'b0;
        tick();
        reset = 1'b1;
        bus0.pulse = 1'b1;
        tick();
        check_eq("rst_resume_cap", bus0.capture, 16'h0001);
        check_eq("rst_resume_idx", bus0.capture_idx, 5'd0);

        // two-stage synchroniser, 1-cycle pulse
        bus1.pulse = 1'b1;
        tick();
        check_eq("sync_e1", bus1.capture, 16'h0);
        bus1.pulse = 1'b0;
        tick();
        check_eq("sync_e2", bus1.capture, 16'h0);
        tick();
        check_eq("sync_e3", bus1.capture, 16'h0001);
        tick();
        check_eq("sync_e4", bus1.capture, 16'h0);
        check_eq("sync_e4_idx", bus1.capture_idx, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
